// File: rtl/regfile_scheduler_if.sv
// Bus bundle between the register-file scheduler and its clients.
// It groups the write-back, decode and debug requesters and the
// single-port register file. The scheduler uses the slave modport.
// The requesters and the register file together use the master modport.
interface regfile_scheduler_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
);
  // write-back requester
  logic              I_wb_valid;
  logic [REG_AW-1:0] I_wb_rd;
  logic [XLEN-1:0]   I_wb_data;
  logic              O_wb_ready;
  // decode requester
  logic              I_dec_valid;
  logic [REG_AW-1:0] I_dec_rs1;
  logic [REG_AW-1:0] I_dec_rs2;
  logic              O_dec_ready;
  logic              O_dec_rvalid;
  logic [XLEN-1:0]   O_dec_rdata1;
  logic [XLEN-1:0]   O_dec_rdata2;
  // debug requester
  logic              I_dbg_valid;
  logic              I_dbg_we;
  logic [REG_AW-1:0] I_dbg_addr;
  logic [XLEN-1:0]   I_dbg_wdata;
  logic              O_dbg_ready;
  logic              O_dbg_rvalid;
  logic [XLEN-1:0]   O_dbg_rdata;
  // register file
  logic              O_rf_regwen;
  logic [REG_AW-1:0] O_rf_rs1;
  logic [REG_AW-1:0] O_rf_rs2;
  logic [REG_AW-1:0] O_rf_rd;
  logic [XLEN-1:0]   O_rf_data;
  logic [XLEN-1:0]   I_rf_data1;
  logic [XLEN-1:0]   I_rf_data2;

  modport slave (
    input  I_wb_valid, I_wb_rd, I_wb_data,
    output O_wb_ready,
    input  I_dec_valid, I_dec_rs1, I_dec_rs2,
    output O_dec_ready, O_dec_rvalid, O_dec_rdata1, O_dec_rdata2,
    input  I_dbg_valid, I_dbg_we, I_dbg_addr, I_dbg_wdata,
    output O_dbg_ready, O_dbg_rvalid, O_dbg_rdata,
    output O_rf_regwen, O_rf_rs1, O_rf_rs2, O_rf_rd, O_rf_data,
    input  I_rf_data1, I_rf_data2
  );

  modport master (
    output I_wb_valid, I_wb_rd, I_wb_data,
    input  O_wb_ready,
    output I_dec_valid, I_dec_rs1, I_dec_rs2,
    input  O_dec_ready, O_dec_rvalid, O_dec_rdata1, O_dec_rdata2,
    output I_dbg_valid, I_dbg_we, I_dbg_addr, I_dbg_wdata,
    input  O_dbg_ready, O_dbg_rvalid, O_dbg_rdata,
    input  O_rf_regwen, O_rf_rs1, O_rf_rs2, O_rf_rd, O_rf_data,
    output I_rf_data1, I_rf_data2
  );
endinterface

// File: rtl/regfile_scheduler.sv
// Single-port register-file scheduler.
// Grants one of write-back, decode or debug per cycle. It drives the
// register-file controls from the grant. It steers the read data, which
// returns one cycle later, back to whoever issued the read.
// Optional macro RFSCHED_DEBUG_EN enables the debug port and its
// anti-starvation counter. Without it, debug inputs are ignored and the
// debug outputs stay at 0.
module regfile_scheduler #(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                I_clk,
  input  logic                I_rst,
  regfile_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEC_RD = 2'd1
`ifdef RFSCHED_DEBUG_EN
    ,
    DBG_RD = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;
  logic   gnt_wb;
  logic   gnt_dec;

`ifdef RFSCHED_DEBUG_EN
  logic       gnt_dbg;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       dbg_urgent;

  // A debug request that has lost STARVE_LIMIT times jumps the queue
  assign dbg_urgent = bus.I_dbg_valid && (starve_cnt_q == 8'(STARVE_LIMIT));

  // Fixed-priority grant; nothing is granted while reset is held
  always_comb begin
    gnt_wb  = 1'b0;
    gnt_dec = 1'b0;
    gnt_dbg = 1'b0;
    if (!I_rst) begin
      if (dbg_urgent)           gnt_dbg = 1'b1;
      else if (bus.I_wb_valid)  gnt_wb  = 1'b1;
      else if (bus.I_dec_valid) gnt_dec = 1'b1;
      else if (bus.I_dbg_valid) gnt_dbg = 1'b1;
    end
  end

  // Count lost arbitration rounds of a pending debug request
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.I_dbg_valid || gnt_dbg)
      starve_cnt_d = 8'd0;
    else if (starve_cnt_q != 8'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + 8'd1;
  end

  // Starvation counter register
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) starve_cnt_q <= 8'd0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  assign bus.O_dbg_ready = gnt_dbg;
`else
  logic unused_dbg;
  assign unused_dbg = ^{bus.I_dbg_valid, bus.I_dbg_we, bus.I_dbg_addr,
                        bus.I_dbg_wdata, 8'(STARVE_LIMIT)};

  // Fixed-priority grant (write-back over decode); none during reset
  always_comb begin
    gnt_wb  = 1'b0;
    gnt_dec = 1'b0;
    if (!I_rst) begin
      if (bus.I_wb_valid)       gnt_wb  = 1'b1;
      else if (bus.I_dec_valid) gnt_dec = 1'b1;
    end
  end

  assign bus.O_dbg_ready  = 1'b0;
  assign bus.O_dbg_rvalid = 1'b0;
  assign bus.O_dbg_rdata  = '0;
`endif

  assign bus.O_wb_ready  = gnt_wb;
  assign bus.O_dec_ready = gnt_dec;

  // Register-file controls follow the grant; x0 writes are swallowed
  always_comb begin
    bus.O_rf_regwen = 1'b0;
    bus.O_rf_rs1    = '0;
    bus.O_rf_rs2    = '0;
    bus.O_rf_rd     = '0;
    bus.O_rf_data   = '0;
    if (gnt_wb) begin
      bus.O_rf_regwen = (bus.I_wb_rd != '0);
      bus.O_rf_rd     = bus.I_wb_rd;
      bus.O_rf_data   = bus.I_wb_data;
    end
    if (gnt_dec) begin
      bus.O_rf_rs1 = bus.I_dec_rs1;
      bus.O_rf_rs2 = bus.I_dec_rs2;
    end
`ifdef RFSCHED_DEBUG_EN
    if (gnt_dbg) begin
      if (bus.I_dbg_we) begin
        bus.O_rf_regwen = (bus.I_dbg_addr != '0);
        bus.O_rf_rd     = bus.I_dbg_addr;
        bus.O_rf_data   = bus.I_dbg_wdata;
      end else begin
        bus.O_rf_rs1 = bus.I_dbg_addr;
      end
    end
`endif
  end

  // Tag the read issued this cycle so next cycle's data goes to its owner
  always_comb begin
    state_d = IDLE;
    if (gnt_dec) state_d = DEC_RD;
`ifdef RFSCHED_DEBUG_EN
    else if (gnt_dbg && !bus.I_dbg_we) state_d = DBG_RD;
`endif
  end

  // Read-tag state register; reset drops any in-flight read
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign bus.O_dec_rvalid = (state_q == DEC_RD);
  assign bus.O_dec_rdata1 = (state_q == DEC_RD) ? bus.I_rf_data1 : '0;
  assign bus.O_dec_rdata2 = (state_q == DEC_RD) ? bus.I_rf_data2 : '0;

`ifdef RFSCHED_DEBUG_EN
  assign bus.O_dbg_rvalid = (state_q == DBG_RD);
  assign bus.O_dbg_rdata  = (state_q == DBG_RD) ? bus.I_rf_data1 : '0;
`endif

endmodule

// File: tb/tb_regfile_scheduler.sv
// Directed bench for regfile_scheduler with a behavioural register file.
// A scoreboard queue holds expected read returns; one entry is pushed per read grant.
module tb_regfile_scheduler;
  localparam int XLEN   = 32;
  localparam int REG_AW = 4;

  typedef struct packed {
    logic        is_dbg;
    logic [31:0] d1;
    logic [31:0] d2;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        env_init;
  int          n_pass  = 0;
  int          n_total = 0;
  rd_exp_t     exp_q[$];
  logic [31:0] model_rf [16];
  logic [31:0] rf_mem   [16];

  regfile_scheduler_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

  regfile_scheduler #(.XLEN(XLEN), .REG_AW(REG_AW), .STARVE_LIMIT(8)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-port register file: x0 reads zero, read data one cycle later
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (bus.O_rf_regwen && bus.O_rf_rd != 4'd0) begin
      rf_mem[bus.O_rf_rd] <= bus.O_rf_data;
    end
    bus.I_rf_data1 <= (bus.O_rf_rs1 == 4'd0) ? 32'd0 : rf_mem[bus.O_rf_rs1];
    bus.I_rf_data2 <= (bus.O_rf_rs2 == 4'd0) ? 32'd0 : rf_mem[bus.O_rf_rs2];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (observed timeout, required $finish)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic chk_grant(input string tag, input logic wb, input logic dec, input logic dbg);
    chk({tag, "_wb_ready"},  32'(bus.O_wb_ready),  32'(wb));
    chk({tag, "_dec_ready"}, 32'(bus.O_dec_ready), 32'(dec));
    chk({tag, "_dbg_ready"}, 32'(bus.O_dbg_ready), 32'(dbg));
  endtask

  // Advance to the next falling edge and compare read returns with the scoreboard
  task automatic tick();
    rd_exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_dbg) begin
        chk("dbg_rvalid", 32'(bus.O_dbg_rvalid), 32'd1);
        chk("dbg_rdata",  bus.O_dbg_rdata, e.d1);
        chk("dec_rvalid_quiet", 32'(bus.O_dec_rvalid), 32'd0);
      end else begin
        chk("dec_rvalid", 32'(bus.O_dec_rvalid), 32'd1);
        chk("dec_rdata1", bus.O_dec_rdata1, e.d1);
        chk("dec_rdata2", bus.O_dec_rdata2, e.d2);
        chk("dbg_rvalid_quiet", 32'(bus.O_dbg_rvalid), 32'd0);
      end
    end else begin
      chk("dec_rvalid_idle", 32'(bus.O_dec_rvalid), 32'd0);
      chk("dec_rdata1_idle", bus.O_dec_rdata1, 32'd0);
      chk("dbg_rvalid_idle", 32'(bus.O_dbg_rvalid), 32'd0);
      chk("dbg_rdata_idle",  bus.O_dbg_rdata, 32'd0);
    end
  endtask

  task automatic set_wb(input logic v, input logic [3:0] rd, input logic [31:0] d);
    bus.I_wb_valid = v; bus.I_wb_rd = rd; bus.I_wb_data = d;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] rs1, input logic [3:0] rs2);
    bus.I_dec_valid = v; bus.I_dec_rs1 = rs1; bus.I_dec_rs2 = rs2;
  endtask

  task automatic set_dbg(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d);
    bus.I_dbg_valid = v; bus.I_dbg_we = we; bus.I_dbg_addr = a; bus.I_dbg_wdata = d;
  endtask

  task automatic idle();
    set_wb(1'b0, 4'd0, 32'd0);
    set_dec(1'b0, 4'd0, 4'd0);
    set_dbg(1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic exp_write(input logic [3:0] rd, input logic [31:0] d);
    if (rd != 4'd0) model_rf[rd] = d;
  endtask

  task automatic exp_dec_read(input logic [3:0] rs1, input logic [3:0] rs2);
    exp_q.push_back('{is_dbg: 1'b0, d1: model_rf[rs1], d2: model_rf[rs2]});
  endtask

  task automatic exp_dbg_read(input logic [3:0] a);
    exp_q.push_back('{is_dbg: 1'b1, d1: model_rf[a], d2: 32'd0});
  endtask

  task automatic chk_rf_quiet(input string tag);
    chk({tag, "_regwen"}, 32'(bus.O_rf_regwen), 32'd0);
    chk({tag, "_rs1"},    32'(bus.O_rf_rs1), 32'd0);
    chk({tag, "_rs2"},    32'(bus.O_rf_rs2), 32'd0);
    chk({tag, "_rd"},     32'(bus.O_rf_rd), 32'd0);
    chk({tag, "_data"},   bus.O_rf_data, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    env_init = 1'b1;
    for (int i = 0; i < 16; i++) model_rf[i] = (i == 0) ? 32'd0 : (32'hA500_0000 | 32'(i));
    idle();
    // requests present during reset must not be granted
    set_wb(1'b1, 4'd5, 32'hDEAD_BEEF);
    set_dec(1'b1, 4'd1, 4'd2);
    set_dbg(1'b1, 1'b1, 4'd6, 32'h1111_2222);
    repeat (2) @(negedge clk);
    env_init = 1'b0;
    #1;
    chk_grant("rst", 1'b0, 1'b0, 1'b0);
    chk_rf_quiet("rst_rf");
    chk("rst_dec_rvalid", 32'(bus.O_dec_rvalid), 32'd0);
    idle();
    rst = 1'b0;

    // write x5 then read it back through decode
    tick(); set_wb(1'b1, 4'd5, 32'hDEAD_BEEF); #1;
    chk_grant("wb_alone", 1'b1, 1'b0, 1'b0);
    chk("wb_regwen", 32'(bus.O_rf_regwen), 32'd1);
    chk("wb_rd", 32'(bus.O_rf_rd), 32'd5);
    chk("wb_data", bus.O_rf_data, 32'hDEAD_BEEF);
    exp_write(4'd5, 32'hDEAD_BEEF);

    tick(); set_wb(1'b0, 4'd0, 32'd0); set_dec(1'b1, 4'd5, 4'd0); #1;
    chk_grant("dec_alone", 1'b0, 1'b1, 1'b0);
    chk("dec_regwen", 32'(bus.O_rf_regwen), 32'd0);
    chk("dec_rs1", 32'(bus.O_rf_rs1), 32'd5);
    chk("dec_rs2", 32'(bus.O_rf_rs2), 32'd0);
    exp_dec_read(4'd5, 4'd0);

    tick(); idle(); #1;
    chk_grant("no_req", 1'b0, 1'b0, 1'b0);
    chk_rf_quiet("no_req_rf");

    // simultaneous wb and dec: wb first, dec sees the new value
    tick(); set_wb(1'b1, 4'd7, 32'hCAFE_F00D); set_dec(1'b1, 4'd7, 4'd5); #1;
    chk_grant("wb_over_dec", 1'b1, 1'b0, 1'b0);
    exp_write(4'd7, 32'hCAFE_F00D);

    tick(); set_wb(1'b0, 4'd0, 32'd0); #1;
    chk_grant("dec_after_wb", 1'b0, 1'b1, 1'b0);
    exp_dec_read(4'd7, 4'd5);

    // back-to-back decode reads
    tick(); set_dec(1'b1, 4'd1, 4'd2); #1;
    chk_grant("b2b_first", 1'b0, 1'b1, 1'b0);
    exp_dec_read(4'd1, 4'd2);

    tick(); set_dec(1'b1, 4'd3, 4'd4); #1;
    chk_grant("b2b_second", 1'b0, 1'b1, 1'b0);
    exp_dec_read(4'd3, 4'd4);

    // write to x0 is accepted but suppressed
    tick(); set_dec(1'b0, 4'd0, 4'd0); set_wb(1'b1, 4'd0, 32'h1234_5678); #1;
    chk_grant("wb_x0", 1'b1, 1'b0, 1'b0);
    chk("wb_x0_regwen", 32'(bus.O_rf_regwen), 32'd0);
    exp_write(4'd0, 32'h1234_5678);

    tick(); set_wb(1'b0, 4'd0, 32'd0); set_dec(1'b1, 4'd0, 4'd7); #1;
    chk_grant("dec_x0", 1'b0, 1'b1, 1'b0);
    exp_dec_read(4'd0, 4'd7);

    tick(); idle(); #1;

    // reset during the cycle a read returns drops it
    tick(); set_dec(1'b1, 4'd2, 4'd3); #1;
    chk_grant("pre_rst_dec", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("inflight_rvalid", 32'(bus.O_dec_rvalid), 32'd1);
    chk("inflight_rdata1", bus.O_dec_rdata1, model_rf[2]);
    rst = 1'b1;
    set_dec(1'b0, 4'd0, 4'd0);
    set_wb(1'b1, 4'd8, 32'h0F0F_0F0F);
    #1;
    chk("rst_drop_rvalid", 32'(bus.O_dec_rvalid), 32'd0);
    chk("rst_drop_rdata1", bus.O_dec_rdata1, 32'd0);
    chk_grant("rst_mid", 1'b0, 1'b0, 1'b0);
    chk_rf_quiet("rst_mid_rf");
    tick();
    tick(); set_wb(1'b0, 4'd0, 32'd0); rst = 1'b0;
    tick(); tick(); tick();

`ifdef RFSCHED_DEBUG_EN
    // wb held continuously starves debug until the limit is reached
    for (int k = 1; k <= 8; k++) begin
      tick(); set_wb(1'b1, 4'd9, 32'h0BAD_F00D); set_dbg(1'b1, 1'b0, 4'd3, 32'd0); #1;
      chk_grant($sformatf("starve_lose%0d", k), 1'b1, 1'b0, 1'b0);
      exp_write(4'd9, 32'h0BAD_F00D);
    end
    tick(); #1;
    chk_grant("starve_win", 1'b0, 1'b0, 1'b1);
    chk("starve_win_rs1", 32'(bus.O_rf_rs1), 32'd3);
    exp_dbg_read(4'd3);

    // counter cleared by the grant: the next debug request loses again
    tick(); set_dbg(1'b1, 1'b0, 4'd9, 32'd0); #1;
    chk_grant("starve_cleared", 1'b1, 1'b0, 1'b0);
    exp_write(4'd9, 32'h0BAD_F00D);

    tick(); set_wb(1'b0, 4'd0, 32'd0); #1;
    chk_grant("dbg_low_prio", 1'b0, 1'b0, 1'b1);
    exp_dbg_read(4'd9);

    // debug write to x0 is accepted but suppressed, x0 still reads 0
    tick(); set_dbg(1'b1, 1'b1, 4'd0, 32'h1234_5678); #1;
    chk_grant("dbg_wr_x0", 1'b0, 1'b0, 1'b1);
    chk("dbg_wr_x0_regwen", 32'(bus.O_rf_regwen), 32'd0);

    tick(); set_dbg(1'b1, 1'b0, 4'd0, 32'd0); #1;
    chk_grant("dbg_rd_x0", 1'b0, 1'b0, 1'b1);
    exp_dbg_read(4'd0);

    tick(); set_dbg(1'b1, 1'b1, 4'd4, 32'h55AA_55AA); #1;
    chk_grant("dbg_wr", 1'b0, 1'b0, 1'b1);
    chk("dbg_wr_regwen", 32'(bus.O_rf_regwen), 32'd1);
    chk("dbg_wr_rd", 32'(bus.O_rf_rd), 32'd4);
    chk("dbg_wr_data", bus.O_rf_data, 32'h55AA_55AA);
    exp_write(4'd4, 32'h55AA_55AA);

    tick(); set_dbg(1'b0, 1'b0, 4'd0, 32'd0); set_dec(1'b1, 4'd4, 4'd9); #1;
    chk_grant("dec_after_dbg_wr", 1'b0, 1'b1, 1'b0);
    exp_dec_read(4'd4, 4'd9);
    tick(); idle(); #1;
`else
    // debug disabled: a held debug request never gets anything
    for (int k = 0; k < 20; k++) begin
      tick();
      set_dbg(1'b1, 1'(k % 2), 4'(k % 16), 32'h7700_0000 + 32'(k));
      if (k % 2 == 0) begin
        set_dec(1'b0, 4'd0, 4'd0);
        set_wb(1'b1, 4'(k / 2 + 1), 32'h1000_0000 + 32'(k));
        #1;
        chk_grant($sformatf("nodbg_wb%0d", k), 1'b1, 1'b0, 1'b0);
        exp_write(4'(k / 2 + 1), 32'h1000_0000 + 32'(k));
      end else begin
        set_wb(1'b0, 4'd0, 32'd0);
        set_dec(1'b1, 4'((k - 1) / 2 + 1), 4'd5);
        #1;
        chk_grant($sformatf("nodbg_dec%0d", k), 1'b0, 1'b1, 1'b0);
        exp_dec_read(4'((k - 1) / 2 + 1), 4'd5);
      end
    end
    tick(); idle(); #1;
`endif

    tick();
    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
